// File: rtl/seq_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_control_unit_if
//  Brief    : Memory-controller request bus (Valid/ready level handshake).
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_control_unit_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              Valid;
    logic              RW;

    modport master (input data, input ready, output Valid, output RW);
    modport slave  (output data, output ready, input Valid, input RW);
endinterface
`default_nettype wire

// File: rtl/seq_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_control_unit
//  Brief    : Multi-cycle fetch/decode/execute/write-back sequencer with
//             branch, halt and memory-handshake timeout trap.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_control_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    seq_control_unit_if.master  mem,
    input  logic                zero,
    output logic                fetch,
    output logic                Addwr_En,
    output logic                Datawr_En,
    output logic                DataBus_En,
    output logic                regEn,
    output logic                store_en,
    output logic                PCEn,
    output logic                Branch_En,
    output logic                increment,
    output logic [5:0]          opcode,
    output logic [4:0]          oppA,
    output logic [4:0]          oppB,
    output logic [DATA_W-1:0]   literal,
    output logic                halted,
    output logic                err
);

    localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [1:0]       C_CLS_RR  = 2'b10;
    localparam logic [1:0]       C_CLS_RI  = 2'b11;
    localparam logic [1:0]       C_CLS_LS  = 2'b01;

    // BOOT supplies the single edge between reset release and the first FETCH outputs
    typedef enum logic [3:0] {
        S_BOOT, S_FETCH, S_DECODE, S_ARITH, S_WB, S_LS_ADDR, S_LOAD_REQ,
        S_LOAD_WB, S_STORE_REQ, S_BRANCH, S_TAKEN, S_NEXT, S_HALT, S_ERROR
    } state_t;

    state_t             r_state, w_state_next;
    logic [1:0]         r_ir_cls, w_ir_cls;
    logic [4:0]         r_ir_dest, w_ir_dest;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_armed;
    logic               r_valid, r_rw;
    logic               w_req, w_done, w_tmo, w_taken;
    logic [31:0]        w_inst;
    logic               w_valid, w_rw, w_fetch, w_addwr, w_datawr, w_databus;
    logic               w_regen, w_store, w_pcen, w_branch, w_incr, w_halted, w_err;
    logic [5:0]         w_opcode;
    logic [4:0]         w_oppA, w_oppB;
    logic [DATA_W-1:0]  w_literal;
    logic               w_unused;

    assign mem.Valid = r_valid;
    assign mem.RW    = r_rw;
    assign w_unused  = ^mem.data;

    always_comb begin
        w_inst  = mem.data[31:0];
        w_req   = (r_state == S_FETCH) || (r_state == S_LOAD_REQ) || (r_state == S_STORE_REQ);
        w_done  = w_req && r_armed && mem.ready;
        w_tmo   = w_req && !w_done && (TIMEOUT != 0) && (r_cnt == C_CNT_MAX);
        w_taken = 1'b0;
        w_state_next = r_state;

        case (r_state)
            S_BOOT:      w_state_next = S_FETCH;
            S_FETCH:     if (w_done) w_state_next = S_DECODE;
                         else if (w_tmo) w_state_next = S_ERROR;
            S_DECODE: begin
                if ((r_ir_cls == C_CLS_RR) || (r_ir_cls == C_CLS_RI)) w_state_next = S_ARITH;
                else if (r_ir_cls == C_CLS_LS)                        w_state_next = S_LS_ADDR;
                else                                                  w_state_next = S_BRANCH;
            end
            S_ARITH:     w_state_next = S_WB;
            S_WB:        w_state_next = S_NEXT;
            S_LS_ADDR: begin
                case (opcode[2:0])
                    3'b000:  w_state_next = S_LOAD_REQ;
                    3'b001:  w_state_next = S_STORE_REQ;
                    default: w_state_next = S_NEXT;
                endcase
            end
            S_LOAD_REQ:  if (w_done) w_state_next = S_LOAD_WB;
                         else if (w_tmo) w_state_next = S_ERROR;
            S_LOAD_WB:   w_state_next = S_NEXT;
            S_STORE_REQ: if (w_done) w_state_next = S_NEXT;
                         else if (w_tmo) w_state_next = S_ERROR;
            S_BRANCH: begin
                case (opcode[2:0])
                    3'b000:  w_taken = 1'b1;
                    3'b001:  w_taken = zero;
                    3'b010:  w_taken = !zero;
                    default: w_taken = 1'b0;
                endcase
                if (opcode[2:0] == 3'b111) w_state_next = S_HALT;
                else if (w_taken)          w_state_next = S_TAKEN;
                else                       w_state_next = S_NEXT;
            end
            S_TAKEN:     w_state_next = S_FETCH;
            S_NEXT:      w_state_next = S_FETCH;
            S_HALT:      w_state_next = S_HALT;
            S_ERROR:     w_state_next = S_ERROR;
            default:     w_state_next = S_ERROR;
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        w_valid   = 1'b0;  w_rw      = 1'b0;  w_fetch  = 1'b0;  w_addwr  = 1'b0;
        w_datawr  = 1'b0;  w_databus = 1'b0;  w_regen  = 1'b0;  w_store  = 1'b0;
        w_pcen    = 1'b0;  w_branch  = 1'b0;  w_incr   = 1'b0;  w_halted = 1'b0;
        w_err     = 1'b0;
        w_opcode  = opcode;
        w_oppA    = oppA;
        w_oppB    = oppB;
        w_literal = literal;
        w_ir_cls  = r_ir_cls;
        w_ir_dest = r_ir_dest;

        case (w_state_next)
            S_FETCH: begin
                w_fetch = 1'b1;  w_addwr = 1'b1;  w_valid = 1'b1;  w_rw = 1'b1;
            end
            S_DECODE: begin
                w_ir_cls  = w_inst[31:30];
                w_ir_dest = w_inst[25:21];
                w_opcode  = w_inst[31:26];
                w_oppA    = w_inst[20:16];
                if (w_inst[31:30] == C_CLS_RR) begin
                    w_oppB    = w_inst[15:11];
                    w_literal = '0;
                end else begin
                    w_literal = {{(DATA_W-16){1'b0}}, w_inst[15:0]};
                end
            end
            S_ARITH:     w_datawr = 1'b1;
            S_WB: begin
                w_oppA  = r_ir_dest;
                w_regen = 1'b1;
            end
            S_LS_ADDR:   w_addwr = 1'b1;
            S_LOAD_REQ: begin
                w_oppA  = r_ir_dest;
                w_valid = 1'b1;  w_rw = 1'b1;
            end
            S_LOAD_WB: begin
                w_store = 1'b1;  w_regen = 1'b1;
            end
            S_STORE_REQ: begin
                w_oppA    = r_ir_dest;
                w_literal = '0;
                w_datawr  = 1'b1;  w_databus = 1'b1;  w_valid = 1'b1;
            end
            S_TAKEN: begin
                w_branch = 1'b1;  w_pcen = 1'b1;
            end
            S_NEXT:      w_incr   = 1'b1;
            S_HALT:      w_halted = 1'b1;
            S_ERROR:     w_err    = 1'b1;
            default:     w_err    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_ir_cls   <= 2'b00;
            r_ir_dest  <= 5'd0;
            r_cnt      <= '0;
            r_armed    <= 1'b0;
            r_valid    <= 1'b0;
            r_rw       <= 1'b0;
            fetch      <= 1'b0;
            Addwr_En   <= 1'b0;
            Datawr_En  <= 1'b0;
            DataBus_En <= 1'b0;
            regEn      <= 1'b0;
            store_en   <= 1'b0;
            PCEn       <= 1'b0;
            Branch_En  <= 1'b0;
            increment  <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
            opcode     <= 6'd0;
            oppA       <= 5'd0;
            oppB       <= 5'd0;
            literal    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ir_cls   <= w_ir_cls;
            r_ir_dest  <= w_ir_dest;
            r_valid    <= w_valid;
            r_rw       <= w_rw;
            fetch      <= w_fetch;
            Addwr_En   <= w_addwr;
            Datawr_En  <= w_datawr;
            DataBus_En <= w_databus;
            regEn      <= w_regen;
            store_en   <= w_store;
            PCEn       <= w_pcen;
            Branch_En  <= w_branch;
            increment  <= w_incr;
            halted     <= w_halted;
            err        <= w_err;
            opcode     <= w_opcode;
            oppA       <= w_oppA;
            oppB       <= w_oppB;
            literal    <= w_literal;
            // Handshake arms on the first ready=0 sample; counter and arm restart on every state change
            if (w_state_next != r_state) begin
                r_cnt   <= '0;
                r_armed <= 1'b0;
            end else if (w_req) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (!mem.ready) r_armed <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_control_unit
//  Brief    : Directed scoreboard bench for seq_control_unit (TIMEOUT = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_control_unit;

    localparam logic [12:0] B_VALID = 13'd1 << 12;
    localparam logic [12:0] B_RW    = 13'd1 << 11;
    localparam logic [12:0] B_FETCH = 13'd1 << 10;
    localparam logic [12:0] B_ADDWR = 13'd1 << 9;
    localparam logic [12:0] B_DATWR = 13'd1 << 8;
    localparam logic [12:0] B_DBUS  = 13'd1 << 7;
    localparam logic [12:0] B_REGEN = 13'd1 << 6;
    localparam logic [12:0] B_STORE = 13'd1 << 5;
    localparam logic [12:0] B_PCEN  = 13'd1 << 4;
    localparam logic [12:0] B_BRAN  = 13'd1 << 3;
    localparam logic [12:0] B_INCR  = 13'd1 << 2;
    localparam logic [12:0] B_HALT  = 13'd1 << 1;
    localparam logic [12:0] B_ERR   = 13'd1;

    localparam logic [12:0] X_NONE  = 13'd0;
    localparam logic [12:0] X_FETCH = B_VALID | B_RW | B_FETCH | B_ADDWR;
    localparam logic [12:0] X_ARITH = B_DATWR;
    localparam logic [12:0] X_WB    = B_REGEN;
    localparam logic [12:0] X_LSA   = B_ADDWR;
    localparam logic [12:0] X_LREQ  = B_VALID | B_RW;
    localparam logic [12:0] X_LWB   = B_STORE | B_REGEN;
    localparam logic [12:0] X_SREQ  = B_VALID | B_DATWR | B_DBUS;
    localparam logic [12:0] X_TAKEN = B_PCEN | B_BRAN;
    localparam logic [12:0] X_NEXT  = B_INCR;

    localparam logic [31:0] I_ARITH = 32'h8022_0800;
    localparam logic [31:0] I_IMM   = 32'hC443_00FF;
    localparam logic [31:0] I_LOAD  = 32'h40A6_1234;
    localparam logic [31:0] I_STORE = 32'h44E8_00AB;
    localparam logic [31:0] I_BRZ   = 32'h0400_0010;
    localparam logic [31:0] I_HALT  = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        zero = 1'b0;
    logic        fetch, Addwr_En, Datawr_En, DataBus_En, regEn, store_en;
    logic        PCEn, Branch_En, increment, halted, err;
    logic [5:0]  opcode;
    logic [4:0]  oppA, oppB;
    logic [31:0] literal;
    logic [12:0] ctrl;

    typedef struct {
        string       tag;
        logic [12:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    seq_control_unit_if #(.DATA_W(32)) bus ();

    seq_control_unit #(.DATA_W(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (bus),
        .zero       (zero),
        .fetch      (fetch),
        .Addwr_En   (Addwr_En),
        .Datawr_En  (Datawr_En),
        .DataBus_En (DataBus_En),
        .regEn      (regEn),
        .store_en   (store_en),
        .PCEn       (PCEn),
        .Branch_En  (Branch_En),
        .increment  (increment),
        .opcode     (opcode),
        .oppA       (oppA),
        .oppB       (oppB),
        .literal    (literal),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    assign ctrl = {bus.Valid, bus.RW, fetch, Addwr_En, Datawr_En, DataBus_En,
                   regEn, store_en, PCEn, Branch_En, increment, halted, err};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the control word expected after the edge, then compare it
    task automatic tick(input logic rdy, input logic [31:0] dat, input logic z,
                        input logic [12:0] exp, input string tag);
        exp_t e;
        bus.ready = rdy;
        bus.data  = dat;
        zero      = z;
        e.tag  = tag;
        e.ctrl = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, 64'(ctrl), 64'(e.ctrl));
    endtask

    task automatic do_fetch(input logic [31:0] instr, input int nlow, input string tag);
        for (int i = 0; i < nlow; i++) tick(1'b0, 32'h0, 1'b0, X_FETCH, {tag, "_wait"});
        tick(1'b1, instr, 1'b0, X_NONE, {tag, "_decode"});
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ctrl"},    64'(ctrl),    64'd0);
        chk({tag, "_opcode"},  64'(opcode),  64'd0);
        chk({tag, "_oppA"},    64'(oppA),    64'd0);
        chk({tag, "_oppB"},    64'(oppB),    64'd0);
        chk({tag, "_literal"}, 64'(literal), 64'd0);
    endtask

    task automatic restart();
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "boot_fetch");
    endtask

    initial begin
        bus.ready = 1'b0;
        bus.data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        reset = 1'b0;
        tick(1'b1, 32'h0, 1'b0, X_FETCH, "boot_fetch");

        // register-register arithmetic
        do_fetch(I_ARITH, 3, "rr");
        chk("rr_opcode",  64'(opcode),  64'h20);
        chk("rr_oppA",    64'(oppA),    64'd2);
        chk("rr_oppB",    64'(oppB),    64'd1);
        chk("rr_literal", 64'(literal), 64'd0);
        tick(1'b0, 32'h0, 1'b0, X_ARITH, "rr_arith");
        tick(1'b0, 32'h0, 1'b0, X_WB,    "rr_wb");
        chk("rr_wb_oppA", 64'(oppA), 64'd1);
        tick(1'b0, 32'h0, 1'b0, X_NEXT,  "rr_next");
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "rr_refetch");

        // register-immediate arithmetic
        do_fetch(I_IMM, 1, "ri");
        chk("ri_opcode",  64'(opcode),  64'h31);
        chk("ri_oppA",    64'(oppA),    64'd3);
        chk("ri_oppB",    64'(oppB),    64'd1);
        chk("ri_literal", 64'(literal), 64'h0000_00FF);
        tick(1'b0, 32'h0, 1'b0, X_ARITH, "ri_arith");
        tick(1'b0, 32'h0, 1'b0, X_WB,    "ri_wb");
        chk("ri_wb_oppA", 64'(oppA), 64'd2);
        tick(1'b0, 32'h0, 1'b0, X_NEXT,  "ri_next");
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "ri_refetch");

        // load, with an early ready=1 that must not complete the handshake
        do_fetch(I_LOAD, 1, "ld");
        chk("ld_opcode",  64'(opcode),  64'h10);
        chk("ld_literal", 64'(literal), 64'h1234);
        tick(1'b0, 32'h0, 1'b0, X_LSA,  "ld_addr");
        tick(1'b0, 32'h0, 1'b0, X_LREQ, "ld_req");
        chk("ld_req_oppA", 64'(oppA), 64'd5);
        tick(1'b1, 32'h0, 1'b0, X_LREQ, "ld_unarmed");
        tick(1'b0, 32'h0, 1'b0, X_LREQ, "ld_arm");
        tick(1'b1, 32'h0, 1'b0, X_LWB,  "ld_wb");
        tick(1'b0, 32'h0, 1'b0, X_NEXT, "ld_next");
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "ld_refetch");

        // store
        do_fetch(I_STORE, 1, "st");
        chk("st_literal", 64'(literal), 64'hAB);
        tick(1'b0, 32'h0, 1'b0, X_LSA,  "st_addr");
        tick(1'b0, 32'h0, 1'b0, X_SREQ, "st_req");
        chk("st_req_literal", 64'(literal), 64'd0);
        chk("st_req_oppA",    64'(oppA),    64'd7);
        tick(1'b0, 32'h0, 1'b0, X_SREQ, "st_arm");
        tick(1'b1, 32'h0, 1'b0, X_NEXT, "st_next");
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "st_refetch");

        // branch-if-zero, taken then not taken
        do_fetch(I_BRZ, 1, "bt");
        tick(1'b0, 32'h0, 1'b0, X_NONE,  "bt_branch");
        tick(1'b0, 32'h0, 1'b1, X_TAKEN, "bt_taken");
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "bt_refetch");
        do_fetch(I_BRZ, 1, "bn");
        tick(1'b0, 32'h0, 1'b0, X_NONE,  "bn_branch");
        tick(1'b0, 32'h0, 1'b0, X_NEXT,  "bn_next");
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "bn_refetch");

        // halt is terminal and issues no further requests
        do_fetch(I_HALT, 1, "hl");
        tick(1'b0, 32'h0, 1'b0, X_NONE, "hl_branch");
        tick(1'b0, 32'h0, 1'b0, B_HALT, "hl_enter");
        for (int i = 0; i < 20; i++) tick(i[0], I_ARITH, 1'b0, B_HALT, "hl_hold");

        // ready stuck low: cycles 0..7 stay in FETCH, cycle 8 traps
        restart();
        for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b0, X_FETCH, "to_wait");
        tick(1'b0, 32'h0, 1'b0, B_ERR, "to_error");
        tick(1'b1, I_ARITH, 1'b0, B_ERR, "to_hold");

        // completion on the timeout cycle wins
        restart();
        for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b0, X_FETCH, "tw_wait");
        tick(1'b1, I_ARITH, 1'b0, X_NONE, "tw_decode");
        tick(1'b0, 32'h0, 1'b0, X_ARITH, "tw_arith");
        tick(1'b0, 32'h0, 1'b0, X_WB,    "tw_wb");
        tick(1'b0, 32'h0, 1'b0, X_NEXT,  "tw_next");

        // asynchronous reset in the middle of a load request
        tick(1'b0, 32'h0, 1'b0, X_FETCH, "ar_fetch");
        do_fetch(I_LOAD, 1, "ar");
        tick(1'b0, 32'h0, 1'b0, X_LSA,  "ar_addr");
        tick(1'b0, 32'h0, 1'b0, X_LREQ, "ar_req");
        #2;
        reset     = 1'b1;
        bus.ready = 1'b1;
        #1;
        chk_zero_outputs("ar_abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1'b1, I_ARITH, 1'b0, X_FETCH, "ar_boot");
        tick(1'b1, I_ARITH, 1'b0, X_FETCH, "ar_unarmed");
        tick(1'b0, 32'h0,   1'b0, X_FETCH, "ar_arm");
        tick(1'b1, I_ARITH, 1'b0, X_NONE,  "ar_decode");
        chk("ar_opcode", 64'(opcode), 64'h20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_control_unit.md
# seq_control_unit

Parametrised multi-cycle instruction sequencer that drives the datapath, register file, PC and memory controller. It runs fetch / decode / execute / write-back as one explicit FSM and talks to the memory controller over a level Valid/ready handshake. Beyond plain sequencing it adds:
- branch and halt instructions, using a zero-flag input;
- a handshake timeout that traps to an error state;
- a configurable literal width.

## Interface
Parameters:
- DATA_W, 32: width of `data` and `literal`; must be ≥ 32.
- TIMEOUT, 255: maximum cycles per memory request before trapping; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data  in  DATA_W  memory read data; IR takes bits [31:0].
- ready  in  1  memory controller ready.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- Valid  out  1  memory request valid.
- RW  out  1  1 = read, 0 = write.
- fetch, Addwr_En, Datawr_En, DataBus_En, regEn, store_en, PCEn, Branch_En, increment  out  1 each  datapath enables.
- opcode  out  6  IR[31:26].
- oppA, oppB  out  5 each  register addresses.
- literal  out  DATA_W  zero-extended immediate.
- halted  out  1  halt instruction executed.
- err  out  1  handshake timeout trap.

## Operation
- All outputs are registered. An output changes on the clock edge that enters the state driving it.
- Any output not listed for a state is 0. `opcode`, `oppA`, `oppB` and `literal` hold their value unless a state loads them.
- Instruction decode:
  - class = IR[31:30]; dest = IR[25:21]; srcA = IR[20:16]; srcB = IR[15:11]; imm = IR[15:0].
  - Class 10: register-register arithmetic.
  - Class 11: register-immediate arithmetic.
  - Class 01: load/store.
  - Class 00: branch.
- Handshake (every request state):
  - Valid is held at 1 while in the state.
  - The handshake arms on the first cycle `ready` is sampled 0.
  - It completes on the first later cycle `ready` is sampled 1.
  - `ready` = 1 before arming is ignored.
  - A timeout counter clears on entry and increments each cycle. If it reaches TIMEOUT before completion, go to ERROR.
- States:
  - FETCH: fetch=Addwr_En=Valid=RW=1. On completion: IR←data[31:0], go to DECODE.
  - DECODE (1 cycle): opcode←IR[31:26], oppA←srcA.
    - Class 10: oppB←srcB, literal←0, go to ARITH.
    - Class 11: literal←imm, go to ARITH.
    - Class 01: literal←imm, go to LS_ADDR.
    - Class 00: literal←imm, go to BRANCH.
  - ARITH: Datawr_En=1, go to WB.
  - WB: oppA←dest, regEn=1, go to NEXT.
  - LS_ADDR: Addwr_En=1.
    - opcode[2:0]=000: go to LOAD_REQ.
    - opcode[2:0]=001: go to STORE_REQ.
    - Otherwise: go to NEXT.
  - LOAD_REQ: oppA←dest, Valid=RW=1. On completion go to LOAD_WB.
  - LOAD_WB: store_en=regEn=1, go to NEXT.
  - STORE_REQ: oppA←dest, literal←0, Datawr_En=DataBus_En=Valid=1, RW=0. On completion go to NEXT.
  - BRANCH, by opcode[2:0]:
    - 000: always taken.
    - 001: taken if zero=1.
    - 010: taken if zero=0.
    - 111: go to HALT.
    - Other codes: go to NEXT.
    - If taken: go to TAKEN. If not taken: go to NEXT.
  - TAKEN: Branch_En=PCEn=1, go to FETCH. There is no increment.
  - NEXT: increment=1, go to FETCH.
  - HALT: halted=1, all enables 0. Terminal until reset.
  - ERROR: err=1, all enables 0, Valid=0. Terminal until reset.

## Timing
- Reset:
  - Every output is 0, including Valid, RW, halted, err, opcode, oppA, oppB and literal. IR=0.
  - State goes to FETCH; the first FETCH outputs appear on the first clk edge after reset falls.
- Reset asserted mid-operation (including during a handshake) aborts immediately and asynchronously; Valid drops with reset.
- Latency, with H = cycles spent in a request state:
  - Arithmetic instruction: H_fetch + 4 cycles (DECODE, ARITH, WB, NEXT).
  - Load: H_fetch + H_load + 4.
  - Store: H_fetch + H_store + 3.
  - Taken branch: H_fetch + 3.
  - Not-taken branch: H_fetch + 3.
- Minimum H is 2: one cycle with ready=0, then one with ready=1.
- Valid falls on the edge leaving the request state.
- Timeout: ERROR is entered on the edge after the counter equals TIMEOUT. A completion in that same cycle wins.
- Unknown class is impossible, since all 4 codes are defined. Undefined sub-opcodes execute as NOP via NEXT.

## Test plan
- Arithmetic fetch: reset, then ready 0→1 after 3 cycles with data=0x8022_0800 (class 10, dest 1, srcA 2, srcB 1) -> opcode=0x20, oppA=2 then 1, oppB=1, literal=0; pulse order Datawr_En, regEn, increment, each exactly 1 cycle.
- Immediate: data=0xC443_00FF -> literal=0x0000_00FF; same ARITH/WB/NEXT sequence; total 4 cycles after the capture edge.
- Load and store, opcode 0x10 then 0x11:
  - Load: Addwr_En, then Valid=RW=1 until handshake, then store_en=regEn=1 for one cycle.
  - Store: RW=0, DataBus_En=1, literal=0 during the request.
- Branches:
  - opcode 0x01 with zero=1 -> Branch_En=PCEn=1 for one cycle and increment never pulses.
  - Same with zero=0 -> increment pulses instead.
  - opcode 0x07 -> halted=1 held for 20 cycles; no further Valid.
- Timeout, TIMEOUT=8, ready stuck at 0 during FETCH -> err=1 and Valid=0 after 8 cycles; a second run with ready rising on cycle 8 completes normally.
- Reset in LOAD_REQ -> Valid=0 immediately and all outputs 0; FETCH restarts after reset releases; ready=1 while not armed is ignored.
